// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction
// memory and registers the returned word into the IF/ID entry.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 256,
   parameter logic [31:0] NOP      = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        if_ready,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus4,
   output logic [31:0] if_instr,
   output logic        fault,
   output logic [31:0] fetch_count
);

   localparam logic [1:0] S_BOOT = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_HALT = 2'd2;

   // One extra bit so DEPTH*4 cannot wrap for large memories.
   localparam logic [32:0] PC_LIMIT = 33'(DEPTH) * 33'd4;

   logic [1:0]  state;
   logic [31:0] pc;
   logic        pc_bad;
   logic        slot_free;

   assign imem_addr = pc;
   assign pc_bad    = (pc[1:0] != 2'b00) || ({1'b0, pc} >= PC_LIMIT);
   assign slot_free = !if_valid || if_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_BOOT;
         pc          <= RESET_PC;
         if_valid    <= 1'b0;
         if_pc       <= '0;
         if_pc_plus4 <= '0;
         if_instr    <= NOP;
         fault       <= 1'b0;
         fetch_count <= '0;
      end else begin
         case (state)
            S_BOOT: state <= S_RUN;
            S_RUN: begin
               // Redirect wins over both the fault check and a capture.
               if (redirect_valid) begin
                  pc       <= redirect_pc;
                  if_valid <= 1'b0;
                  if_instr <= NOP;
               end else if (pc_bad) begin
                  state    <= S_HALT;
                  fault    <= 1'b1;
                  if_valid <= 1'b0;
                  if_instr <= NOP;
               end else if (slot_free) begin
                  if_instr    <= imem_instr;
                  if_pc       <= pc;
                  if_pc_plus4 <= pc + 32'd4;
                  if_valid    <= 1'b1;
                  pc          <= pc + 32'd4;
                  fetch_count <= fetch_count + 32'd1;
               end
            end
            S_HALT: state <= S_HALT;
            default: begin
               state    <= S_HALT;
               fault    <= 1'b1;
               if_valid <= 1'b0;
               if_instr <= NOP;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: scoreboard of expected IF/ID entries plus
// direct checks of stall, redirect, fault and asynchronous reset behaviour.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst, rst4;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_ready;
   logic [31:0] imem_addr, imem_instr;
   logic        if_valid, fault;
   logic [31:0] if_pc, if_pc_plus4, if_instr, fetch_count;

   logic        zero4, one4;
   logic [31:0] rpc4;
   logic [31:0] imem_addr4, imem_instr4;
   logic        if_valid4, fault4;
   logic [31:0] if_pc4, if_pc_plus44, if_instr4, fetch_count4;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   logic [31:0] sb_pc[$];

   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [31:0] a);
      return 32'hC0DE_0000 ^ a;
   endfunction

   assign imem_instr  = word(imem_addr);
   assign imem_instr4 = word(imem_addr4);

   fetch_unit #(.RESET_PC(32'h0), .DEPTH(256), .NOP(NOP)) dut (
      .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .if_ready(if_ready), .imem_addr(imem_addr), .imem_instr(imem_instr),
      .if_valid(if_valid), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .if_instr(if_instr),
      .fault(fault), .fetch_count(fetch_count)
   );

   fetch_unit #(.RESET_PC(32'h0), .DEPTH(4), .NOP(NOP)) dut4 (
      .clk(clk), .rst(rst4), .redirect_valid(zero4), .redirect_pc(rpc4),
      .if_ready(one4), .imem_addr(imem_addr4), .imem_instr(imem_instr4),
      .if_valid(if_valid4), .if_pc(if_pc4), .if_pc_plus4(if_pc_plus44), .if_instr(if_instr4),
      .fault(fault4), .fetch_count(fetch_count4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag);
      logic [31:0] p;
      if (sb_pc.size() == 0) begin
         vectors++;
         miscompares++;
         $error("FAIL %s scoreboard empty observed_pc=%h expected=entry", tag, if_pc);
      end else begin
         p = sb_pc.pop_front();
         chk({tag, "_valid"}, {31'b0, if_valid}, 32'd1);
         chk({tag, "_pc"}, if_pc, p);
         chk({tag, "_pc4"}, if_pc_plus4, p + 32'd4);
         chk({tag, "_instr"}, if_instr, word(p));
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_valid"}, {31'b0, if_valid}, 32'd0);
      chk({tag, "_fault"}, {31'b0, fault}, 32'd0);
      chk({tag, "_addr"}, imem_addr, 32'h0);
      chk({tag, "_instr"}, if_instr, NOP);
      chk({tag, "_count"}, fetch_count, 32'd0);
   endtask

   initial begin
      rst = 1'b1; rst4 = 1'b1;
      zero4 = 1'b0; one4 = 1'b1; rpc4 = 32'h0;
      redirect_valid = 1'b0; redirect_pc = 32'h0; if_ready = 1'b1;
      #1;
      chk_reset("reset");
      chk("reset_ifpc", if_pc, 32'h0);
      chk("reset_ifpc4", if_pc_plus4, 32'h0);
      repeat (2) step();
      rst = 1'b0; rst4 = 1'b0;

      // Free run: BOOT edge, then 0,4,8,12 on consecutive edges.
      step();
      chk("boot_valid", {31'b0, if_valid}, 32'd0);
      sb_pc.push_back(32'h0); sb_pc.push_back(32'h4);
      sb_pc.push_back(32'h8); sb_pc.push_back(32'hC);
      step(); expect_out("run0");
      step(); expect_out("run1");
      step(); expect_out("run2");
      step(); expect_out("run3");
      chk("run_count", fetch_count, 32'd4);
      chk("d4_count", fetch_count4, 32'd4);
      chk("d4_valid", {31'b0, if_valid4}, 32'd1);
      chk("d4_fault_pre", {31'b0, fault4}, 32'd0);

      // Stall on the entry at 12 for three edges.
      if_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_pc", if_pc, 32'hC);
         chk("stall_instr", if_instr, word(32'hC));
         chk("stall_valid", {31'b0, if_valid}, 32'd1);
         chk("stall_addr", imem_addr, 32'h10);
         chk("stall_count", fetch_count, 32'd4);
         if (i == 0) begin
            chk("d4_fault", {31'b0, fault4}, 32'd1);
            chk("d4_valid_halt", {31'b0, if_valid4}, 32'd0);
            chk("d4_count_halt", fetch_count4, 32'd4);
            chk("d4_addr_halt", imem_addr4, 32'h10);
         end
      end
      if_ready = 1'b1;
      sb_pc.push_back(32'h10);
      step(); expect_out("release");
      chk("release_count", fetch_count, 32'd5);

      // Redirect with if_ready=1: one bubble, then the target.
      redirect_valid = 1'b1; redirect_pc = 32'h40;
      step();
      redirect_valid = 1'b0;
      chk("redir_valid", {31'b0, if_valid}, 32'd0);
      chk("redir_instr", if_instr, NOP);
      chk("redir_addr", imem_addr, 32'h40);
      chk("redir_count", fetch_count, 32'd5);
      sb_pc.push_back(32'h40);
      step(); expect_out("target");
      chk("target_count", fetch_count, 32'd6);

      // Misaligned redirect: accepted, then halt on the next edge.
      redirect_valid = 1'b1; redirect_pc = 32'h6;
      step();
      redirect_valid = 1'b0;
      chk("mis_addr", imem_addr, 32'h6);
      chk("mis_fault_pre", {31'b0, fault}, 32'd0);
      step();
      chk("mis_fault", {31'b0, fault}, 32'd1);
      chk("mis_valid", {31'b0, if_valid}, 32'd0);
      chk("mis_instr", if_instr, NOP);
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      repeat (2) step();
      redirect_valid = 1'b0;
      step();
      chk("halt_addr", imem_addr, 32'h6);
      chk("halt_fault", {31'b0, fault}, 32'd1);
      chk("halt_valid", {31'b0, if_valid}, 32'd0);
      chk("halt_count", fetch_count, 32'd6);
      chk("d4_fault_held", {31'b0, fault4}, 32'd1);

      // Asynchronous reset while halted clears the fault between edges.
      #2 rst = 1'b1;
      #1 chk_reset("rst_halt");
      step();
      rst = 1'b0;
      step();
      chk("boot2_valid", {31'b0, if_valid}, 32'd0);
      sb_pc.push_back(32'h0);
      step(); expect_out("first");

      // Stall straight after the first capture.
      if_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall0_pc", if_pc, 32'h0);
         chk("stall0_instr", if_instr, word(32'h0));
         chk("stall0_addr", imem_addr, 32'h4);
         chk("stall0_count", fetch_count, 32'd1);
      end
      if_ready = 1'b1;
      sb_pc.push_back(32'h4); sb_pc.push_back(32'h8);
      step(); expect_out("rel0");
      step(); expect_out("rel1");

      // Asynchronous reset mid-stream, then resume from RESET_PC.
      #3 rst = 1'b1;
      #1 chk_reset("rst_mid");
      #2 rst = 1'b0;
      step();
      chk("boot3_valid", {31'b0, if_valid}, 32'd0);
      sb_pc.push_back(32'h0); sb_pc.push_back(32'h4);
      step(); expect_out("resume0");
      step(); expect_out("resume1");
      chk("resume_count", fetch_count, 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the single-issue RV32I core. Holds the program counter, drives the byte address into the combinational instruction memory, and registers the returned word into the IF/ID pipeline register. Handles branch/jump redirects (flushing the in-flight fetch), downstream back-pressure, and halts with a sticky fault on a misaligned or out-of-range PC.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- DEPTH, 256, instruction memory size in 32-bit words; valid byte addresses are 0 .. DEPTH*4-4
- NOP, 32'h0000_0013, value held in if_instr when no valid instruction is present (addi x0,x0,0)

- clk  in  1  rising-edge clock; the only clock
- rst  in  1  asynchronous, active-high reset
- redirect_valid  in  1  branch/jump taken; load redirect_pc
- redirect_pc  in  32  redirect target byte address
- if_ready  in  1  decode accepts the IF/ID entry this cycle
- imem_addr  out  32  byte address to instruction memory (= pc, combinational)
- imem_instr  in  32  word returned combinationally by instruction memory for imem_addr
- if_valid  out  1  IF/ID entry holds a valid instruction
- if_pc  out  32  byte address of if_instr
- if_pc_plus4  out  32  if_pc + 4 (mod 2^32)
- if_instr  out  32  fetched instruction
- fault  out  1  sticky: fetch halted on bad PC
- fetch_count  out  32  instructions captured into IF/ID since reset, wraps at 2^32

## Operation
- State machine: BOOT, RUN, HALT.
  - BOOT: entered on reset; lasts exactly one clk edge; no capture; then RUN.
  - RUN: normal fetch.
  - HALT: no capture, pc frozen, if_valid=0, fault=1; exits only on rst.
- Reset values: pc=RESET_PC, if_valid=0, if_pc=0, if_pc_plus4=0, if_instr=NOP, fault=0, fetch_count=0, state=BOOT.
- "pc bad" = pc[1:0]!=0 or pc >= DEPTH*4.
- Per edge in RUN, priority order:
  1. redirect_valid=1: pc<=redirect_pc; if_valid<=0, if_instr<=NOP (flush); no capture. Takes priority over capture even when if_ready=1.
  2. pc bad: state<=HALT, fault<=1, if_valid<=0, if_instr<=NOP.
  3. Slot free (if_valid=0 or if_ready=1): if_instr<=imem_instr, if_pc<=pc, if_pc_plus4<=pc+4, if_valid<=1, pc<=pc+4, fetch_count<=fetch_count+1.
  4. Otherwise (if_valid=1, if_ready=0): hold all registers (stall).
- When if_ready=1 and the slot was valid but no new capture happens (redirect, fault), if_valid drops to 0.
- Redirect to a bad PC is accepted into pc; the fault is taken on the next RUN edge (rule 2).
- redirect_valid is ignored in BOOT and HALT.
- Arithmetic: pc+4 and fetch_count are modulo 2^32; upper bits of imem_addr are not masked.

## Timing
- imem_addr tracks pc with zero latency; the instruction at pc appears on if_instr one edge later.
- Redirect asserted before edge N: imem_addr=redirect_pc after N; target instruction valid on if_* after N+1. Exactly one bubble.
- Throughput: one instruction per cycle while if_ready=1.
- First if_valid: second edge after rst deasserts (BOOT edge, then capture at RESET_PC).
- Stall: if_* outputs are stable while if_valid=1 and if_ready=0.
- Async rst mid-operation: all outputs take reset values immediately, independent of clk.

## Test plan
- Reset, if_ready=1, memory words 0..3 = A,B,C,D: after BOOT, if_pc = 0,4,8,12 on consecutive cycles with if_instr A..D; fetch_count=4.
- Hold if_ready=0 for 3 cycles after the first capture: if_pc stays 0, if_instr stays A, pc stays 4, fetch_count stays 1; release: next if_pc=4.
- redirect_valid with redirect_pc=0x40 in the same cycle as if_ready=1: next cycle if_valid=0, if_instr=NOP; following cycle if_pc=0x40, if_pc_plus4=0x44.
- DEPTH=4, free-run from 0: captures 0..12, then fault=1, if_valid=0, fetch_count=4, held until rst.
- redirect_pc=0x6 (misaligned): next edge enters HALT; fault=1; later redirect_valid pulses ignored.
- Assert rst asynchronously mid-stream (between edges): if_valid=0, fault=0, imem_addr=RESET_PC immediately; fetch resumes from RESET_PC after BOOT.
